// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - frame format and FSM state shared by spi_reg master and slave
package spi_reg_pkg;

   localparam int FRAME_BITS = 16;
   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 8;

   localparam logic HDR_WRITE = 1'b1;
   localparam logic HDR_READ  = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   // Read frames carry zeros in the data field so the slave sees a clean idle MOSI.
   function automatic logic [FRAME_BITS-1:0] pack_frame(
      input logic              wr,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] wdata
   );
      return {(wr ? HDR_WRITE : HDR_READ), addr, (wr ? wdata : {DATA_W{1'b0}})};
   endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// rtl/spi_sclk_div.sv - loadable down-counter timing every FSM phase
module spi_sclk_div #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire,
   output logic             penult
);

   logic [CNT_W-1:0] cnt;
   logic             running;

   // A load of N makes the current phase last exactly N cycles, expire marking the last one.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         running <= 1'b0;
      end else if (load) begin
         cnt     <= load_val - CNT_W'(1);
         running <= 1'b1;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end else begin
         running <= 1'b0;
      end
   end

   assign expire = running && (cnt == '0);
   assign penult = running && (cnt == CNT_W'(1));

endmodule

// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - SPI mode-0 master issuing 16-bit register read/write frames
module spi_reg_master
   import spi_reg_pkg::*;
#(
   parameter int CLK_DIV  = 6,
   parameter int CS_SETUP = 12,
   parameter int CS_HOLD  = 10,
   parameter int CS_GAP   = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              spi_clk,
   output logic              spi_cs,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] DIV_V   = CNT_W'(CLK_DIV);
   localparam logic [CNT_W-1:0] SETUP_V = CNT_W'(CS_SETUP);
   localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(CS_HOLD);
   localparam logic [CNT_W-1:0] GAP_V   = CNT_W'(CS_GAP);

   state_t                  state;
   logic [FRAME_BITS-1:0]   frame;
   logic                    rd;
   logic [3:0]              bit_cnt;
   logic [DATA_W-1:0]       rx;
   logic                    accept;
   logic                    last_bit;
   logic                    load;
   logic [CNT_W-1:0]        load_val;
   logic                    expire;
   logic                    penult;

   assign accept   = (state == IDLE) && cmd_valid && cmd_ready;
   assign last_bit = spi_clk && (bit_cnt == 4'd15);

   always_comb begin
      load     = 1'b0;
      load_val = DIV_V;
      case (state)
         IDLE:  begin load = accept; load_val = SETUP_V; end
         SETUP: load = expire;
         SHIFT: begin load = expire; load_val = last_bit ? HOLD_V : DIV_V; end
         HOLD:  begin load = expire; load_val = GAP_V; end
         default: load = 1'b0;
      endcase
   end

   spi_sclk_div #(.CNT_W(CNT_W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .expire   (expire),
      .penult   (penult)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         frame     <= '0;
         rd        <= 1'b0;
         bit_cnt   <= '0;
         rx        <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         spi_clk   <= 1'b0;
         spi_cs    <= 1'b1;
         spi_mosi  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               frame     <= pack_frame(cmd_write, cmd_addr, cmd_wdata);
               rd        <= ~cmd_write;
               rx        <= '0;
               spi_cs    <= 1'b0;
               spi_clk   <= 1'b0;
               spi_mosi  <= cmd_write;
               cmd_ready <= 1'b0;
               busy      <= 1'b1;
               state     <= SETUP;
            end
            SETUP: if (expire) begin
               spi_clk <= 1'b1;
               bit_cnt <= '0;
               state   <= SHIFT;
            end
            // Each bit is a high phase then a low phase; the last bit has no low phase.
            SHIFT: if (expire) begin
               if (spi_clk) begin
                  spi_clk <= 1'b0;
                  if (last_bit) begin
                     state <= HOLD;
                  end else begin
                     frame    <= frame << 1;
                     spi_mosi <= frame[FRAME_BITS-2];
                  end
               end else begin
                  spi_clk <= 1'b1;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt >= 4'd7) begin
                     rx <= {rx[DATA_W-2:0], spi_miso};
                  end
               end
            end
            HOLD: if (expire) begin
               spi_cs   <= 1'b1;
               spi_mosi <= 1'b0;
               state    <= GAP;
               if (CS_GAP == 1) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd ? rx : '0;
               end
            end
            // The response pulse lands on the final GAP cycle, so it is launched one cycle early.
            GAP: begin
               if (penult) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd ? rx : '0;
               end
               if (expire) begin
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_reg_master.sv
// tb/tb_spi_reg_master.sv - directed self-checking bench for spi_reg_master with a register-slave model
module tb_spi_reg_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_write;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       cmd_ready, rsp_valid, busy, spi_clk, spi_cs, spi_mosi, spi_miso;
   logic [7:0] rsp_rdata;

   logic       f_cmd_valid, f_cmd_write;
   logic [6:0] f_cmd_addr;
   logic [7:0] f_cmd_wdata;
   logic       f_cmd_ready, f_rsp_valid, f_busy, f_spi_clk, f_spi_cs, f_spi_mosi;
   logic       f_spi_miso = 1'b1;
   logic [7:0] f_rsp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #8 clk = ~clk;

   spi_reg_master u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   spi_reg_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u_fast (
      .clk(clk), .rst(rst), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
      .cmd_write(f_cmd_write), .cmd_addr(f_cmd_addr), .cmd_wdata(f_cmd_wdata),
      .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
      .spi_clk(f_spi_clk), .spi_cs(f_spi_cs), .spi_mosi(f_spi_mosi), .spi_miso(f_spi_miso)
   );

   // Register slave model: MOSI taken on SCLK rise, MISO launched on SCLK fall.
   bit   [7:0]  mem [0:127];
   int          s_cnt = 0;
   logic [15:0] s_sh  = '0;
   logic [6:0]  s_addr = '0;
   logic [7:0]  s_tmp;
   logic        force_en  = 1'b0;
   logic [7:0]  force_val = 8'h00;
   int          rsp_cnt = 0;

   always @(posedge spi_clk or negedge spi_cs) begin
      if (!spi_clk) begin
         s_cnt = 0;
      end else if (!spi_cs) begin
         s_sh = {s_sh[14:0], spi_mosi};
         s_cnt++;
         if (s_cnt == 8) s_addr = s_sh[6:0];
         if (s_cnt == 16 && s_sh[15]) mem[s_sh[14:8]] = s_sh[7:0];
      end
   end

   always @(negedge spi_clk or negedge spi_cs) begin
      if (!spi_cs && s_cnt >= 8 && s_cnt < 16) begin
         s_tmp    = force_en ? force_val : mem[s_addr];
         spi_miso = s_tmp[15 - s_cnt];
      end else begin
         spi_miso = 1'b0;
      end
   end

   always @(posedge clk) if (rsp_valid) rsp_cnt++;

   int          f_cnt = 0;
   logic [15:0] f_sh  = '0;
   always @(posedge f_spi_clk or negedge f_spi_cs) begin
      if (!f_spi_clk) f_cnt = 0;
      else if (!f_spi_cs) begin
         f_sh = {f_sh[14:0], f_spi_mosi};
         f_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_cmd(input logic w, input logic [6:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int lat, output int cs_low, output logic bad);
      int k;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      k = 0;
      while (!cmd_ready && k < 1000) begin @(negedge clk); k++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1; cs_low = 0; bad = 1'b0; rd = 8'hxx;
      forever begin
         lat++;
         if (!spi_cs) cs_low++;
         if (cmd_ready || !busy) bad = 1'b1;
         if (rsp_valid) begin rd = rsp_rdata; break; end
         if (lat > 5000) break;
         @(negedge clk);
      end
   endtask

   task automatic do_fast(input logic w, input logic [6:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
      int k;
      @(negedge clk);
      f_cmd_valid = 1'b1; f_cmd_write = w; f_cmd_addr = a; f_cmd_wdata = d;
      k = 0;
      while (!f_cmd_ready && k < 1000) begin @(negedge clk); k++; end
      @(negedge clk);
      f_cmd_valid = 1'b0;
      lat = 1; rd = 8'hxx;
      forever begin
         lat++;
         if (f_rsp_valid) begin rd = f_rsp_rdata; break; end
         if (lat > 1000) break;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] rd;
      int         lat, cs_low, k, n, hi_run, min_gap, gaps, rsp0;
      logic       bad, acc_next, seen_low;

      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      f_cmd_valid = 1'b0; f_cmd_write = 1'b0; f_cmd_addr = '0; f_cmd_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", 32'(spi_cs), 32'd1);
      check("rst_clk", 32'(spi_clk), 32'd0);
      check("rst_mosi", 32'(spi_mosi), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", 32'(rsp_rdata), 32'h00);
      @(negedge clk);
      rst = 1'b0;

      // Write 0x05 <= 0xA5 at default timing
      do_cmd(1'b1, 7'h05, 8'hA5, rd, lat, cs_low, bad);
      check("w05_frame", 32'(s_sh), 32'h85A5);
      check("w05_rises", 32'(s_cnt), 32'd16);
      check("w05_cs_low", 32'(cs_low), 32'd208);
      check("w05_latency", 32'(lat), 32'd239);
      check("w05_rdata", 32'(rd), 32'h00);
      check("w05_ready_busy", 32'(bad), 32'd0);
      check("w05_slave_mem", 32'(mem[5]), 32'hA5);

      // Top address, read back through the slave, then a forced MISO pattern
      do_cmd(1'b1, 7'h7F, 8'h3C, rd, lat, cs_low, bad);
      check("w7f_frame", 32'(s_sh), 32'hFF3C);
      do_cmd(1'b0, 7'h7F, 8'hAA, rd, lat, cs_low, bad);
      check("r7f_frame", 32'(s_sh), 32'h7F00);
      check("r7f_rdata", 32'(rd), 32'h3C);
      check("r7f_latency", 32'(lat), 32'd239);
      force_en = 1'b1; force_val = 8'hC3;
      do_cmd(1'b0, 7'h7F, 8'h00, rd, lat, cs_low, bad);
      force_en = 1'b0;
      check("r7f_forced_rdata", 32'(rd), 32'hC3);

      // Back-to-back: cmd_valid held for three writes
      @(negedge clk);
      rsp0 = rsp_cnt; n = 0; acc_next = 1'b0; hi_run = 0; min_gap = 9999; gaps = 0;
      seen_low = 1'b0; bad = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h10; cmd_wdata = 8'hB0;
      for (k = 0; k < 1200 && (rsp_cnt - rsp0) < 3; k++) begin
         if (acc_next) begin
            n++;
            cmd_addr = 7'(7'h10 + n); cmd_wdata = 8'(8'hB0 + n);
            if (n == 3) cmd_valid = 1'b0;
         end
         acc_next = cmd_valid && cmd_ready;
         if (spi_cs) hi_run++;
         else begin
            if (cmd_ready) bad = 1'b1;
            if (seen_low && hi_run > 0) begin
               gaps++;
               if (hi_run < min_gap) min_gap = hi_run;
            end
            seen_low = 1'b1; hi_run = 0;
         end
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      check("b2b_rsp_count", 32'(rsp_cnt - rsp0), 32'd3);
      check("b2b_gaps", 32'(gaps), 32'd2);
      check("b2b_min_gap_ge30", 32'(min_gap >= 30), 32'd1);
      check("b2b_ready_low", 32'(bad), 32'd0);
      check("b2b_mem10", 32'(mem[7'h10]), 32'hB0);
      check("b2b_mem12", 32'(mem[7'h12]), 32'hB2);

      // Reset after the 5th SCLK rise of a write frame
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h22; cmd_wdata = 8'hEE;
      k = 0;
      while (!cmd_ready && k < 1000) begin @(negedge clk); k++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      k = 0;
      while (s_cnt < 5 && k < 1000) begin @(negedge clk); k++; end
      check("rst_mid_reached_rise5", 32'(s_cnt), 32'd5);
      rsp0 = rsp_cnt;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_cs", 32'(spi_cs), 32'd1);
      check("rst_mid_clk", 32'(spi_clk), 32'd0);
      check("rst_mid_mosi", 32'(spi_mosi), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("rst_mid_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      check("rst_mid_no_write", 32'(mem[7'h22]), 32'h00);
      do_cmd(1'b1, 7'h22, 8'h5A, rd, lat, cs_low, bad);
      check("rst_after_frame", 32'(s_sh), 32'hA25A);
      check("rst_after_latency", 32'(lat), 32'd239);
      check("rst_after_mem", 32'(mem[7'h22]), 32'h5A);

      // Minimum timing instance
      do_fast(1'b1, 7'h12, 8'h34, rd, lat);
      check("fast_w_latency", 32'(lat), 32'd35);
      check("fast_w_rises", 32'(f_cnt), 32'd16);
      check("fast_w_frame", 32'(f_sh), 32'h9234);
      check("fast_w_rdata", 32'(rd), 32'h00);
      do_fast(1'b0, 7'h55, 8'h77, rd, lat);
      check("fast_r_frame", 32'(f_sh), 32'h5500);
      check("fast_r_rdata", 32'(rd), 32'hFF);
      check("fast_r_latency", 32'(lat), 32'd35);

      // Sixteen writes then sixteen reads through the slave
      for (int i = 0; i < 16; i++) do_cmd(1'b1, 7'(i), 8'(i), rd, lat, cs_low, bad);
      for (int i = 0; i < 16; i++) begin
         do_cmd(1'b0, 7'(i), 8'hFF, rd, lat, cs_low, bad);
         check($sformatf("sweep_read_%0d", i), 32'(rd), 32'(i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
